sprite_engine: RTL and testbench

Scanline sprite renderer, successor to the single-frame line sprite. Draws one sprite per scanline from external graphic memory, with:
- multi-frame animation select
- horizontal and vertical mirroring
- power-of-two X/Y scaling
- transparent colour key
- configurable memory read latency
- direct vertical hit test, so no per-line start control is needed

Sits between the display timing generator, the sprite ROM/BRAM and the pixel compositor.

---
 rtl/sprite_engine.sv | 152 +++++++++++++++
 tb/tb_sprite_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// Scanline sprite renderer: fetches one row of an animated, mirrorable, scaled
// sprite from graphic memory and aligns the returned pixels with the screen x.
module sprite_engine #(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 16,
  parameter int FRAMES     = 4,
  parameter int SCALE_X    = 2,
  parameter int SCALE_Y    = 2,
  parameter int COLR_BITS  = 4,
  parameter int CORDW      = 16,
  parameter int ADDRW      = 10,
  parameter int MEM_LAT    = 2,
  parameter int TRANS_COLR = 0
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_line,
  input  logic signed [CORDW-1:0]                    i_sx,
  input  logic signed [CORDW-1:0]                    i_sy,
  input  logic signed [CORDW-1:0]                    i_sprx,
  input  logic signed [CORDW-1:0]                    i_spry,
  input  logic [(FRAMES > 1 ? $clog2(FRAMES) : 1)-1:0] i_frame,
  input  logic                                       i_flip_x,
  input  logic                                       i_flip_y,
  input  logic [COLR_BITS-1:0]                       i_data,
  output logic [ADDRW-1:0]                           o_addr,
  output logic [COLR_BITS-1:0]                       o_pix,
  output logic                                       o_drawing,
  output logic                                       o_done
);

  localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW    = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SY_SH = $clog2(SCALE_Y);
  localparam int LW    = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, CHECK, AWAIT_POS, DRAW, FLUSH, DONE} state_t;

  state_t state, state_next;

  logic [RW-1:0]          row_l;
  logic [FW-1:0]          frame_l;
  logic                   flip_x_l;
  logic signed [CORDW-1:0] sprx_l;
  logic [XW-1:0]          ox;
  logic [CW-1:0]          cnt_x;
  logic [LW-1:0]          flush_cnt;
  logic [MEM_LAT-1:0]     vpipe;

  logic signed [CORDW:0]  dy, sx_ext, target;
  logic [RW-1:0]          row_calc;
  logic [XW-1:0]          col;
  logic                   hit, at_pos, past_pos, last_px, draw_active;

  assign dy       = $signed({i_sy[CORDW-1], i_sy}) - $signed({i_spry[CORDW-1], i_spry});
  assign hit      = !dy[CORDW] && (dy[CORDW-1:0] < CORDW'(HEIGHT * SCALE_Y));
  assign row_calc = i_flip_y ? RW'(HEIGHT - 1) - RW'(dy[CORDW-1:0] >> SY_SH)
                             : RW'(dy[CORDW-1:0] >> SY_SH);

  assign sx_ext   = $signed({i_sx[CORDW-1], i_sx});
  assign target   = $signed({sprx_l[CORDW-1], sprx_l}) - (CORDW+1)'(MEM_LAT);
  assign at_pos   = (sx_ext == target);
  assign past_pos = (sx_ext > target);

  assign last_px  = (ox == XW'(WIDTH - 1)) && (cnt_x == CW'(SCALE_X - 1));

  // The matching AWAIT_POS cycle already issues pixel 0, so its data lands at sx == sprx.
  always_comb begin
    state_next  = state;
    draw_active = 1'b0;
    o_done      = 1'b0;
    case (state)
      IDLE:      if (i_line) state_next = CHECK;
      CHECK:     state_next = hit ? AWAIT_POS : DONE;
      AWAIT_POS: begin
        if (at_pos) begin
          draw_active = 1'b1;
          state_next  = last_px ? FLUSH : DRAW;
        end else if (past_pos) begin
          state_next = DONE;
        end
      end
      DRAW: begin
        draw_active = 1'b1;
        if (last_px) state_next = FLUSH;
      end
      FLUSH:     if (flush_cnt == LW'(MEM_LAT - 1)) state_next = DONE;
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
    if (i_line) begin
      state_next  = CHECK;
      draw_active = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_l     <= '0;
      frame_l   <= '0;
      flip_x_l  <= 1'b0;
      sprx_l    <= '0;
      ox        <= '0;
      cnt_x     <= '0;
      flush_cnt <= '0;
      vpipe     <= '0;
    end else begin
      if (i_line) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= draw_active;
        for (int i = 1; i < MEM_LAT; i++) vpipe[i] <= vpipe[i-1];
      end

      if (state == CHECK) begin
        row_l    <= row_calc;
        frame_l  <= (32'(i_frame) < FRAMES) ? i_frame : '0;
        flip_x_l <= i_flip_x;
        sprx_l   <= i_sprx;
        ox       <= '0;
        cnt_x    <= '0;
      end else if (draw_active) begin
        if (cnt_x == CW'(SCALE_X - 1)) begin
          cnt_x <= '0;
          ox    <= (ox == XW'(WIDTH - 1)) ? '0 : ox + XW'(1);
        end else begin
          cnt_x <= cnt_x + CW'(1);
        end
      end

      flush_cnt <= (state == FLUSH) ? flush_cnt + LW'(1) : '0;
    end
  end

  assign col    = flip_x_l ? XW'(WIDTH - 1) - ox : ox;
  assign o_addr = ADDRW'(frame_l) * ADDRW'(WIDTH * HEIGHT)
                + ADDRW'(row_l) * ADDRW'(WIDTH) + ADDRW'(col);

  assign o_drawing = vpipe[MEM_LAT-1] && (i_data != COLR_BITS'(TRANS_COLR));
  assign o_pix     = o_drawing ? i_data : '0;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: table of scanline vectors with a behavioural
// memory, plus hand-written reset and line re-pulse sequences.
module tb_sprite_engine;

  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_line = 1'b0;
  logic signed [15:0] i_sx = '0, i_sy = '0, i_sprx = '0, i_spry = '0;
  logic [1:0]        i_frame = '0;
  logic              i_flip_x = 1'b0, i_flip_y = 1'b0;
  logic [3:0]        i_data;
  logic [9:0]        o_addr;
  logic [3:0]        o_pix;
  logic              o_drawing, o_done;

  sprite_engine dut (
    .i_clk(clk), .i_rst(i_rst), .i_line(i_line),
    .i_sx(i_sx), .i_sy(i_sy), .i_sprx(i_sprx), .i_spry(i_spry),
    .i_frame(i_frame), .i_flip_x(i_flip_x), .i_flip_y(i_flip_y),
    .i_data(i_data), .o_addr(o_addr), .o_pix(o_pix),
    .o_drawing(o_drawing), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Graphic memory with MEM_LAT cycles of read latency.
  logic [3:0] mem [1024];
  logic [9:0] addrPipe [MEM_LAT] = '{default: '0};
  always @(posedge clk) begin
    addrPipe[0] <= o_addr;
    for (int i = 1; i < MEM_LAT; i++) addrPipe[i] <= addrPipe[i-1];
  end
  assign i_data = mem[addrPipe[MEM_LAT-1]];

  typedef struct {
    string name;
    int    sy, sprx, spry, frame;
    bit    fx, fy;
    int    memMode;
    bit    expDraw;
    int    expRow, expFirstAddr, expDoneSx;
  } vec_t;

  int checkCount = 0;
  int passCount  = 0;
  int doneCount, doneSx;

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fillMem(input int mode);
    for (int a = 0; a < 1024; a++)
      mem[a] = (mode == 0) ? 4'(a) : (a[0] ? 4'hA : 4'h0);
  endtask

  function automatic int modelAddr(input vec_t v, input int j);
    int c;
    c = j / 2;
    if (v.fx) c = 15 - c;
    return v.frame * 256 + v.expRow * 16 + c;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
    i_line = 1'b0;
    i_sx   = i_sx + 16'sd1;
  endtask

  // One sampled cycle against the model for vector v.
  task automatic checkCycle(input vec_t v);
    int sx, a;
    logic [3:0] d, p;
    logic expDrawing;
    @(negedge clk);
    sx = int'(i_sx);
    expDrawing = 1'b0;
    p = 4'h0;
    if (v.expDraw && sx >= v.sprx && sx < v.sprx + 32) begin
      d = mem[modelAddr(v, sx - v.sprx)];
      expDrawing = (d != 4'h0);
      p = expDrawing ? d : 4'h0;
    end
    checkOutput($sformatf("%s drawing sx=%0d", v.name, sx), int'(o_drawing), int'(expDrawing));
    checkOutput($sformatf("%s pix sx=%0d", v.name, sx), int'(o_pix), int'(p));
    if (v.expDraw && sx >= v.sprx - 2 && sx < v.sprx + 30)
      checkOutput($sformatf("%s addr sx=%0d", v.name, sx), int'(o_addr),
                  modelAddr(v, sx - (v.sprx - 2)));
    if (v.expDraw && sx == v.sprx - 2)
      checkOutput($sformatf("%s first_addr", v.name), int'(o_addr), v.expFirstAddr);
    if (o_done) begin
      doneCount++;
      doneSx = sx;
    end
  endtask

  task automatic startLine(input vec_t v);
    fillMem(v.memMode);
    i_sy = 16'(v.sy); i_sprx = 16'(v.sprx); i_spry = 16'(v.spry);
    i_frame = 2'(v.frame); i_flip_x = v.fx; i_flip_y = v.fy;
    i_sx = 16'sd90;
    i_line = 1'b1;
    doneCount = 0;
    doneSx = -1;
  endtask

  task automatic applyStimulus(input vec_t v);
    startLine(v);
    for (int sx = 90; sx < 170; sx++) begin
      checkCycle(v);
      advance();
    end
    checkOutput($sformatf("%s done_count", v.name), doneCount, 1);
    checkOutput($sformatf("%s done_sx", v.name), doneSx, v.expDoneSx);
  endtask

  vec_t vecs[12];
  vec_t newVec;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    //        name          sy  sprx spry fr fx fy mm draw row first done
    vecs[0]  = '{"basic",      50, 100, 50, 0, 0, 0, 0, 1, 0,   0, 132};
    vecs[1]  = '{"sy51",       51, 100, 50, 0, 0, 0, 0, 1, 0,   0, 132};
    vecs[2]  = '{"sy52",       52, 100, 50, 0, 0, 0, 0, 1, 1,  16, 132};
    vecs[3]  = '{"flipxy_f2",  50, 100, 50, 2, 1, 1, 0, 1, 15, 767, 132};
    vecs[4]  = '{"miss_above", 49, 100, 50, 0, 0, 0, 0, 0, 0,   0,  92};
    vecs[5]  = '{"miss_below", 82, 100, 50, 0, 0, 0, 0, 0, 0,   0,  92};
    vecs[6]  = '{"last_row",   81, 100, 50, 0, 0, 0, 0, 1, 15, 240, 132};
    vecs[7]  = '{"trans_even", 50, 100, 50, 0, 0, 0, 1, 1, 0,   0, 132};
    vecs[8]  = '{"flipx_f3",   60, 100, 50, 3, 1, 0, 0, 1, 5,  863, 132};
    vecs[9]  = '{"min_left",   50,  94, 50, 0, 0, 0, 0, 1, 0,   0, 126};
    vecs[10] = '{"skip_left",  50,  93, 50, 0, 0, 0, 0, 0, 0,   0,  93};
    vecs[11] = '{"neg_spry",    5, 100, -10, 0, 0, 0, 0, 1, 7, 112, 132};

    fillMem(0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset addr", int'(o_addr), 0);
    checkOutput("reset pix", int'(o_pix), 0);
    checkOutput("reset drawing", int'(o_drawing), 0);
    checkOutput("reset done", int'(o_done), 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Reset asserted in the middle of DRAW.
    startLine(vecs[0]);
    for (int sx = 90; sx < 110; sx++) begin
      checkCycle(vecs[0]);
      advance();
    end
    i_rst = 1'b1;
    checkCycle(vecs[0]);
    checkOutput("rst_mid drawing before", int'(o_drawing), 1);
    advance();
    i_rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid addr", int'(o_addr), 0);
    checkOutput("rst_mid pix", int'(o_pix), 0);
    checkOutput("rst_mid drawing", int'(o_drawing), 0);
    checkOutput("rst_mid done", int'(o_done), 0);
    for (int k = 0; k < 40; k++) begin
      advance();
      @(negedge clk);
      checkOutput($sformatf("rst_mid idle drawing sx=%0d", int'(i_sx)), int'(o_drawing), 0);
      checkOutput($sformatf("rst_mid idle done sx=%0d", int'(i_sx)), int'(o_done), 0);
    end
    @(posedge clk);
    #1;

    // New line pulse in the middle of DRAW: old line aborted, new one drawn at sprx=130.
    newVec = '{"repulse", 52, 130, 50, 0, 0, 0, 0, 1, 1, 16, 162};
    startLine(vecs[0]);
    for (int sx = 90; sx < 110; sx++) begin
      checkCycle(vecs[0]);
      advance();
    end
    i_line = 1'b1;
    i_sy   = 16'sd52;
    i_sprx = 16'sd130;
    checkCycle(vecs[0]);
    checkOutput("repulse drawing before", int'(o_drawing), 1);
    advance();
    for (int sx = 111; sx < 176; sx++) begin
      checkCycle(newVec);
      advance();
    end
    checkOutput("repulse done_count", doneCount, 1);
    checkOutput("repulse done_sx", doneSx, 162);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
